// File: rtl/mfcc_pkg.sv
// rtl/mfcc_pkg.sv - shared constants and FSM encoding for the mel filterbank controller
package mfcc_pkg;

  localparam int MFCC_NUM_BINS   = 257;
  localparam int MFCC_ADDR_WIDTH = 9;
  localparam int MFCC_SPEC_WIDTH = 32;
  localparam int MFCC_W_WIDTH    = 8;
  localparam int MFCC_ACC_WIDTH  = MFCC_SPEC_WIDTH + MFCC_W_WIDTH + MFCC_ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_OUTPUT = 2'd3
  } mel_state_t;

endpackage

// File: rtl/mfcc_mac.sv
// rtl/mfcc_mac.sv - unsigned full-width multiply-accumulate with clear and enable
import mfcc_pkg::*;

module mfcc_mac #(
  parameter int SPEC_WIDTH = MFCC_SPEC_WIDTH,
  parameter int W_WIDTH    = MFCC_W_WIDTH,
  parameter int ACC_WIDTH  = MFCC_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [SPEC_WIDTH-1:0] a,
  input  logic [W_WIDTH-1:0]    b,
  output logic [ACC_WIDTH-1:0]  acc
);

  logic [SPEC_WIDTH+W_WIDTH-1:0] w_prod;
  logic [ACC_WIDTH-1:0]          r_acc;

  assign w_prod = a * b;
  assign acc    = r_acc;

  // clear wins over enable so a new request never inherits a stale product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= r_acc + {{(ACC_WIDTH-SPEC_WIDTH-W_WIDTH){1'b0}}, w_prod};
    end
  end

endmodule

// File: rtl/mfcc_melbank_ctrl.sv
// rtl/mfcc_melbank_ctrl.sv - sweeps one mel filter support and returns its weighted energy
import mfcc_pkg::*;

module mfcc_melbank_ctrl #(
  parameter int NUM_BINS   = MFCC_NUM_BINS,
  parameter int ADDR_WIDTH = MFCC_ADDR_WIDTH,
  parameter int SPEC_WIDTH = MFCC_SPEC_WIDTH,
  parameter int W_WIDTH    = MFCC_W_WIDTH,
  parameter int ACC_WIDTH  = SPEC_WIDTH + W_WIDTH + ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_bin,
  input  logic [ADDR_WIDTH-1:0] end_bin,
  input  logic                  abort,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] spec_addr,
  input  logic [SPEC_WIDTH-1:0] spec_data,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [W_WIDTH-1:0]    rom_data,
  output logic [ACC_WIDTH-1:0]  mel_energy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  range_err
);

  localparam logic [ADDR_WIDTH:0] LP_NUM_BINS = NUM_BINS[ADDR_WIDTH:0];

  mel_state_t            r_state;
  mel_state_t            w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_end;
  logic [W_WIDTH-1:0]    r_weight;
  logic                  r_issued;
  logic                  r_range_err;
  logic                  w_accept;
  logic                  w_legal;
  logic                  w_last;
  logic                  w_mac_en;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_legal  = (start_bin <= end_bin) && ({1'b0, end_bin} < LP_NUM_BINS);
  assign w_last   = (r_addr == r_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = w_legal ? ST_SWEEP : ST_OUTPUT;
      ST_SWEEP:  if (abort) w_next = ST_IDLE;
                 else if (w_last) w_next = ST_DRAIN;
      ST_DRAIN:  w_next = abort ? ST_IDLE : ST_OUTPUT;
      ST_OUTPUT: if (out_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // r_issued marks that the previous cycle drove a bin, so spec_data and r_weight now pair up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_end       <= '0;
      r_weight    <= '0;
      r_issued    <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      r_issued <= (r_state == ST_SWEEP);
      if (r_state == ST_SWEEP) r_weight <= rom_data;
      if (w_accept) begin
        r_end       <= end_bin;
        r_range_err <= !w_legal;
        if (w_legal) r_addr <= start_bin;
      end else if ((r_state == ST_SWEEP) && !w_last) begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  assign w_mac_en = r_issued && ((r_state == ST_SWEEP) || (r_state == ST_DRAIN));

  mfcc_mac #(
    .SPEC_WIDTH (SPEC_WIDTH),
    .W_WIDTH    (W_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_accept),
    .en    (w_mac_en),
    .a     (spec_data),
    .b     (r_weight),
    .acc   (mel_energy)
  );

  assign spec_addr = r_addr;
  assign rom_addr  = r_addr;
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = (r_state == ST_OUTPUT);
  assign range_err = r_range_err;

endmodule

// File: doc/mfcc_melbank_ctrl.md
MFCC_MELBANK_CTRL -- requirements
Module: mfcc_melbank_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_BINS, default 257, giving the spectrum bins per frame.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 9, giving the bin/ROM address width.
REQ-003 The block SHALL have parameter SPEC_WIDTH, default 32, giving the power-spectrum sample width.
REQ-004 The block SHALL have parameter W_WIDTH, default 8, giving the unsigned mel weight width.
REQ-005 The block SHALL have parameter ACC_WIDTH, default SPEC_WIDTH+W_WIDTH+ADDR_WIDTH (49), giving the accumulator/result width.
REQ-006 Port: clk  in  1  single clock; all logic is rising-edge.
REQ-007 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-008 Port: start  in  1  one-cycle request to compute one filter energy.
REQ-009 Port: start_bin  in  ADDR_WIDTH  first bin of the filter support, sampled on accepted start.
REQ-010 Port: end_bin  in  ADDR_WIDTH  last bin, inclusive, sampled on accepted start.
REQ-011 Port: abort  in  1  synchronous cancel of the current sweep.
REQ-012 Port: busy  out  1  high from accepted start until return to IDLE.
REQ-013 Port: spec_addr  out  ADDR_WIDTH  read address to the spectrum buffer (1-cycle read latency).
REQ-014 Port: spec_data  in  SPEC_WIDTH  spectrum buffer read data.
REQ-015 Port: rom_addr  out  ADDR_WIDTH  address to the melbank weight ROM (unregistered, combinational read).
REQ-016 Port: rom_data  in  W_WIDTH  weight ROM read data.
REQ-017 Port: mel_energy  out  ACC_WIDTH  accumulated filter energy.
REQ-018 Port: out_valid / out_ready  out / in  1 each  result handshake.
REQ-019 Port: range_err  out  1  qualifies mel_energy when the requested range was illegal.

Function
REQ-020 States SHALL be IDLE, SWEEP, DRAIN, OUTPUT.
REQ-021 In IDLE, start SHALL be accepted; start while not IDLE SHALL be ignored.
REQ-022 On accepted start, the block SHALL latch start_bin/end_bin, clear the accumulator, and enter SWEEP if start_bin<=end_bin and end_bin<NUM_BINS, otherwise enter OUTPUT with mel_energy=0 and range_err=1.
REQ-023 In SWEEP, spec_addr and rom_addr SHALL be driven equal, one bin per cycle, start_bin..end_bin ascending, no gaps.
REQ-024 rom_data SHALL be registered in the cycle its address is driven so that it aligns with spec_data one cycle later.
REQ-025 Each aligned pair SHALL be multiplied unsigned (full width) and added to the accumulator; no truncation or saturation.
REQ-026 After end_bin is issued, the FSM SHALL enter DRAIN for exactly one cycle to accumulate the last product, then enter OUTPUT.
REQ-027 Latency: with start accepted in cycle 0 and N=end_bin-start_bin+1, out_valid SHALL first be high in cycle N+2.
REQ-028 In OUTPUT, out_valid SHALL remain high and mel_energy/range_err stable until out_ready is high; the FSM then returns to IDLE next cycle.
REQ-029 abort in SWEEP or DRAIN SHALL return to IDLE next cycle without asserting out_valid; abort in OUTPUT or IDLE SHALL have no effect.
REQ-030 Addresses SHALL hold their last value outside SWEEP; downstream reads outside SWEEP are ignored.

Reset
REQ-031 On rst_n low: state=IDLE, busy=0, out_valid=0, range_err=0, mel_energy=0, spec_addr=0, rom_addr=0, accumulator=0.
REQ-032 Reset asserted mid-sweep SHALL discard the sweep; no result is produced after release.

Structure
REQ-033 FSM state encoding and the NUM_BINS/width constants SHALL live in a shared package, mfcc_pkg.
REQ-034 The multiply-accumulate SHALL be a sub-module, mfcc_mac, with clear/enable inputs.

Verification
REQ-035 Bins 0..3 spectrum {10,20,30,40}, weights {1,2,3,4}, start_bin=0,end_bin=3 -> mel_energy=300, out_valid in cycle 6, range_err=0.
REQ-036 start_bin=end_bin=256, spectrum 0xFFFFFFFF, weight 255 -> mel_energy=0xFE_FFFF_FF01, out_valid cycle 3.
REQ-037 start_bin=5,end_bin=4 -> out_valid cycle 1, mel_energy=0, range_err=1; end_bin=300 likewise.
REQ-038 All 257 bins at max value and weight -> mel_energy=257*0xFFFFFFFF*255 exactly, no overflow.
REQ-039 out_ready low for 10 cycles, second start during sweep and OUTPUT -> result held stable, second start ignored.
REQ-040 abort in cycle 3 of a 10-bin sweep, and rst_n low in cycle 4 of another -> no out_valid; next start gives correct fresh sum.
